// File: rtl/serial_nibble_receiver.sv
// serial_nibble_receiver: frames start/data/parity/stop bits into a nibble with 7-seg, error pulses and a good-frame count
module serial_nibble_receiver #(
  parameter int NBITS_DATA = 4,
  parameter int PARITY_EN  = 1,
  parameter int NBITS_CNT  = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  sample_en,
  input  logic                  serial_in,
  output logic [NBITS_DATA-1:0] nibble_out,
  output logic [7:0]            seg,
  output logic                  frame_valid,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic [NBITS_CNT-1:0]  frame_count,
  output logic                  busy
);
  localparam int IW = NBITS_DATA > 1 ? $clog2(NBITS_DATA) : 1;
  localparam logic [7:0] SEG_LUT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t                state, state_n;
  logic [IW-1:0]         bit_idx, idx_n;
  logic [NBITS_DATA-1:0] shift, shift_n;
  logic                  perr, perr_n, good, p_e, f_e;
  assign busy = state != IDLE;
  // next-state, datapath and stop-bit verdict; everything holds unless sample_en
  always_comb begin
    state_n = state;
    idx_n   = bit_idx;
    shift_n = shift;
    perr_n  = perr;
    good    = 1'b0;
    p_e     = 1'b0;
    f_e     = 1'b0;
    if (sample_en)
      case (state)
        IDLE: if (serial_in) begin
          state_n = DATA;
          idx_n   = '0;
          perr_n  = 1'b0;
        end
        DATA: begin
          shift_n[bit_idx] = serial_in;
          idx_n            = bit_idx + IW'(1);
          if (bit_idx == IW'(NBITS_DATA - 1)) state_n = PARITY_EN != 0 ? PARITY : STOP;
        end
        PARITY: begin
          perr_n  = (^shift) ^ serial_in;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          f_e     = serial_in;
          p_e     = !serial_in && perr && PARITY_EN != 0;
          good    = !serial_in && !perr;
        end
      endcase
  end
  // registered state and outputs; pulses last exactly one cycle
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      shift       <= '0;
      perr        <= 1'b0;
      nibble_out  <= '0;
      seg         <= 8'h3F;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      bit_idx     <= idx_n;
      shift       <= shift_n;
      perr        <= perr_n;
      frame_valid <= good;
      parity_err  <= p_e;
      framing_err <= f_e;
      if (good) begin
        nibble_out  <= shift;
        seg         <= SEG_LUT[shift[3:0]];
        frame_count <= frame_count + NBITS_CNT'(1);
      end
    end
  end
endmodule
